set_engine_arbiter: RTL and testbench

- Shares one SET circle-set counting engine between two requesters.
- Round-robin arbitration; drives the engine's en/busy/valid handshake; returns each job's candidate count, tagged with the requester id, over a valid/ready response port.
- One job outstanding at a time.
- A watchdog aborts a job whose engine valid never arrives, so a requester is never left waiting.

---
 rtl/set_pkg.sv | 29 ++
 rtl/set_rr_arb2.sv | 20 ++
 rtl/set_engine_arbiter.sv | 130 +++++++++++++
 tb/tb_set_engine_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// Shared widths, FSM states, mode codes and job record for the SET engine arbiter.
// Combinational definitions only: no latency and no backpressure.
// Imported by every module of the arbiter.
package set_pkg;

    localparam int SET_CENTRAL_W = 24;
    localparam int SET_RADIUS_W  = 12;
    localparam int SET_MODE_W    = 2;
    localparam int SET_CAND_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } set_state_e;

    localparam logic [SET_MODE_W-1:0] MODE_A      = 2'b00;
    localparam logic [SET_MODE_W-1:0] MODE_UNION  = 2'b01;
    localparam logic [SET_MODE_W-1:0] MODE_XOR    = 2'b10;
    localparam logic [SET_MODE_W-1:0] MODE_TRIPLE = 2'b11;

    typedef struct packed {
        logic [SET_CENTRAL_W-1:0] central;
        logic [SET_RADIUS_W-1:0]  radius;
        logic [SET_MODE_W-1:0]    mode;
    } set_job_t;

endpackage

// File: rtl/set_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last time wins.
// Latency: purely combinational, same-cycle grant.
// Backpressure: none; the caller qualifies the grant with its own ready conditions.
module set_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant
);

    always_comb begin
        grant_vld = req0 | req1;
        grant     = req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/set_engine_arbiter.sv
// Shares one SET candidate-count engine between two requesters, one job in flight.
// Latency: accept at T, eng_en at T+1, response at T+2+L (or T+2+TIMEOUT_CYC on abort).
// Backpressure: requesters are held off while a job is in flight, eng_busy is high, or the response is unconsumed.
module set_engine_arbiter
    import set_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [SET_CENTRAL_W-1:0] req0_central,
    input  logic [SET_RADIUS_W-1:0]  req0_radius,
    input  logic [SET_MODE_W-1:0]    req0_mode,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [SET_CENTRAL_W-1:0] req1_central,
    input  logic [SET_RADIUS_W-1:0]  req1_radius,
    input  logic [SET_MODE_W-1:0]    req1_mode,
    output logic                     eng_en,
    output logic [SET_CENTRAL_W-1:0] eng_central,
    output logic [SET_RADIUS_W-1:0]  eng_radius,
    output logic [SET_MODE_W-1:0]    eng_mode,
    input  logic                     eng_busy,
    input  logic                     eng_valid,
    input  logic [SET_CAND_W-1:0]    eng_candidate,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [SET_CAND_W-1:0]    rsp_candidate,
    output logic                     rsp_timeout,
    output logic [CNT_W-1:0]         done_cnt
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    set_state_e       state;
    logic [TMR_W-1:0] timer;
    logic             last_grant;
    logic             grant;
    logic             grant_vld;
    logic             accept;
    logic             cur_id;
    set_job_t         job_q;
    set_job_t         sel_job;

    set_rr_arb2 u_arb (
        .req0       (req0_valid),
        .req1       (req1_valid),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    // rst_n gates the handshake so ready reads 0 the instant reset asserts
    assign accept     = rst_n && (state == IDLE) && !eng_busy && grant_vld;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        sel_job = '{central: req0_central, radius: req0_radius, mode: req0_mode};
        if (grant) begin
            sel_job = '{central: req1_central, radius: req1_radius, mode: req1_mode};
        end
    end

    assign eng_central = job_q.central;
    assign eng_radius  = job_q.radius;
    assign eng_mode    = job_q.mode;
    assign rsp_id      = cur_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            last_grant    <= 1'b1;
            cur_id        <= 1'b0;
            job_q         <= '0;
            eng_en        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_candidate <= '0;
            rsp_timeout   <= 1'b0;
            done_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        job_q      <= sel_job;
                        cur_id     <= grant;
                        last_grant <= grant;
                        eng_en     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_en <= 1'b0;
                    timer  <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // a result landing on the last watchdog cycle still counts
                    if (eng_valid) begin
                        rsp_candidate <= eng_candidate;
                        rsp_timeout   <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else if (timer == TMR_LAST) begin
                        rsp_candidate <= '0;
                        rsp_timeout   <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_engine_arbiter.sv
// Bench for set_engine_arbiter: directed scenarios plus random traffic against a job-level model.
// The model predicts accept cycle, grant owner, eng_en cycle and response contents/timing per job.
module tb_set_engine_arbiter;
    import set_pkg::*;

    localparam int TO    = 16;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [23:0] req0_central, req1_central;
    logic [11:0] req0_radius, req1_radius;
    logic [1:0]  req0_mode, req1_mode;
    logic        eng_en, eng_busy, eng_valid;
    logic [23:0] eng_central;
    logic [11:0] eng_radius;
    logic [1:0]  eng_mode;
    logic [7:0]  eng_candidate;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_timeout;
    logic [7:0]  rsp_candidate;
    logic [15:0] done_cnt;

    logic        eng_valid_m, eng_valid_i;
    logic [7:0]  eng_cand_m, eng_cand_i;
    assign eng_valid     = eng_valid_m | eng_valid_i;
    assign eng_candidate = eng_valid_i ? eng_cand_i : eng_cand_m;

    always #5 clk = ~clk;

    set_engine_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_central(req0_central),
        .req0_radius(req0_radius), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_central(req1_central),
        .req1_radius(req1_radius), .req1_mode(req1_mode),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
        .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_candidate(rsp_candidate), .rsp_timeout(rsp_timeout), .done_cnt(done_cnt)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // per-requester engine behaviour for the job that requester would submit now
    int         req0_lat, req1_lat;
    logic [7:0] req0_cand, req1_cand;

    // job-level reference model state
    bit          m_busy;
    logic        m_last, m_id, m_to;
    int          m_acc, m_due, m_done;
    logic [7:0]  m_cand;
    logic [23:0] m_central;
    logic [11:0] m_radius;
    logic [1:0]  m_mode;
    int          acc_count = 0;
    int          rsp_ids[$];
    int          rsp_cands[$];
    int          plan_lat[$];
    logic [7:0]  plan_cand[$];
    logic        exp_acc, exp_id, exp_en, exp_rv, took_id;
    int          took_lat;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // reference model / monitor, sampling mid-cycle
    initial begin
        m_busy = 0; m_last = 1'b1; m_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_last = 1'b1; m_done = 0;
                plan_lat.delete(); plan_cand.delete();
            end else begin
                exp_acc = !m_busy && !eng_busy && (req0_valid || req1_valid);
                exp_id  = (req0_valid && req1_valid) ? !m_last : req1_valid;
                if (exp_acc || req0_ready || req1_ready)
                    check_eq("accept", {req1_ready, req0_ready}, exp_acc ? (exp_id ? 2 : 1) : 0);

                exp_en = m_busy && (cyc == m_acc + 1);
                if (exp_en || eng_en) begin
                    check_eq("eng_en", eng_en, exp_en);
                    if (exp_en && eng_en) begin
                        check_eq("eng_central", eng_central, m_central);
                        check_eq("eng_radius", eng_radius, m_radius);
                        check_eq("eng_mode", eng_mode, m_mode);
                    end
                end

                exp_rv = m_busy && (cyc >= m_due);
                if (exp_rv || rsp_valid) begin
                    check_eq("rsp_valid", rsp_valid, exp_rv);
                    if (exp_rv && rsp_valid) begin
                        check_eq("rsp_id", rsp_id, m_id);
                        check_eq("rsp_candidate", rsp_candidate, m_cand);
                        check_eq("rsp_timeout", rsp_timeout, m_to);
                        check_eq("eng_hold", eng_central, m_central);
                        if (rsp_ready) begin
                            check_eq("done_cnt", done_cnt, m_done);
                            m_done++;
                            rsp_ids.push_back(int'(rsp_id));
                            rsp_cands.push_back(int'(rsp_candidate));
                            m_busy = 0;
                        end
                    end
                end

                if (exp_acc && (req0_ready || req1_ready)) begin
                    took_id = req1_ready;
                    m_busy = 1; m_acc = cyc; m_id = took_id; m_last = took_id;
                    m_central = took_id ? req1_central : req0_central;
                    m_radius  = took_id ? req1_radius : req0_radius;
                    m_mode    = took_id ? req1_mode : req0_mode;
                    took_lat  = took_id ? req1_lat : req0_lat;
                    if (took_lat <= TO) begin
                        m_cand = took_id ? req1_cand : req0_cand;
                        m_to = 1'b0;
                        m_due = cyc + 2 + took_lat;
                    end else begin
                        m_cand = 8'd0;
                        m_to = 1'b1;
                        m_due = cyc + 2 + TO;
                    end
                    plan_lat.push_back(took_lat);
                    plan_cand.push_back(took_id ? req1_cand : req0_cand);
                    acc_count++;
                end
            end
        end
    end

    // engine model: answers each eng_en after the planned latency, or never
    initial begin
        int         lat;
        logic [7:0] cand;
        eng_valid_m = 1'b0; eng_cand_m = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n && eng_en) begin
                lat = NEVER; cand = 8'd0;
                if (plan_lat.size() > 0) begin
                    lat = plan_lat.pop_front();
                    cand = plan_cand.pop_front();
                end
                if (lat <= TO) begin
                    repeat (lat) @(posedge clk);
                    #1; eng_valid_m = 1'b1; eng_cand_m = cand;
                    @(posedge clk);
                    #1; eng_valid_m = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1);
    end

    task automatic wait_acc(input int tgt, input string tag);
        int k = 0;
        while (acc_count < tgt && k < 300) begin
            @(posedge clk); #1; k++;
        end
        check_eq(tag, acc_count, tgt);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (m_busy && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check_eq(tag, m_busy, 0);
    endtask

    task automatic send(input int id, input logic [23:0] c, input logic [11:0] r,
                        input logic [1:0] m, input int lat, input logic [7:0] cand);
        int tgt;
        tgt = acc_count + 1;
        if (id == 0) begin
            req0_central = c; req0_radius = r; req0_mode = m;
            req0_lat = lat; req0_cand = cand; req0_valid = 1'b1;
        end else begin
            req1_central = c; req1_radius = r; req1_mode = m;
            req1_lat = lat; req1_cand = cand; req1_valid = 1'b1;
        end
        wait_acc(tgt, "send_accept");
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int base, k, tgt;
        bit stale;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_central = '0; req1_central = '0; req0_radius = '0; req1_radius = '0;
        req0_mode = '0; req1_mode = '0;
        req0_lat = 1; req1_lat = 1; req0_cand = '0; req1_cand = '0;
        eng_busy = 1'b0; eng_valid_i = 1'b0; eng_cand_i = '0; rsp_ready = 1'b1;

        // reset state, with a requester asking to be served
        #12 req0_valid = 1'b1;
        #1;
        check_eq("rst_req0_ready", req0_ready, 0);
        check_eq("rst_eng_en", eng_en, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_done_cnt", done_cnt, 0);
        check_eq("rst_eng_central", eng_central, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single job, latency 10
        send(0, 24'h444444, 12'h333, MODE_A, 10, 8'd29);
        wait_idle("t1_idle");
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_cand", rsp_cands[rsp_cands.size()-1], 29);

        // both requesters valid from reset: alternating grants
        apply_reset();
        rsp_ids.delete(); rsp_cands.delete();
        req0_lat = $urandom_range(1, TO); req1_lat = $urandom_range(1, TO);
        req0_cand = 8'd1; req1_cand = 8'd2;
        req0_central = 24'h0A0B0C; req1_central = 24'h102030;
        req0_mode = MODE_UNION; req1_mode = MODE_TRIPLE;
        req0_valid = 1'b1; req1_valid = 1'b1;
        base = acc_count;
        for (int j = 0; j < 4; j++) begin
            wait_acc(base + j + 1, "t2_accept");
            if (j == 0) req0_cand = 8'd3;
            if (j == 1) req1_cand = 8'd4;
            if (j == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        wait_idle("t2_idle");
        check_eq("t2_count", rsp_ids.size(), 4);
        for (int j = 0; j < 4 && j < rsp_ids.size(); j++) begin
            check_eq("t2_id", rsp_ids[j], j % 2);
            check_eq("t2_cand", rsp_cands[j], j + 1);
        end

        // watchdog abort, then a late result in IDLE, then result on the last watchdog cycle
        send(0, 24'h123456, 12'h321, MODE_XOR, NEVER, 8'd0);
        wait_idle("t3_idle");
        check_eq("t3_timeout_cand", rsp_cands[rsp_cands.size()-1], 0);
        eng_cand_i = 8'hEE; eng_valid_i = 1'b1;
        @(posedge clk); #1 eng_valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("t3_late_rsp", rsp_valid, 0);
        end
        check_eq("t3_late_done", done_cnt, m_done);
        send(1, 24'h654321, 12'h777, MODE_A, TO, 8'd64);
        wait_idle("t3_edge_idle");
        check_eq("t3_edge_cand", rsp_cands[rsp_cands.size()-1], 64);
        send(0, 24'h111111, 12'h111, MODE_UNION, 5, 8'd7);
        wait_idle("t3_after_idle");

        // response stall with req1 pending
        rsp_ready = 1'b0;
        send(0, 24'hABCDEF, 12'h222, MODE_A, 3, 8'd55);
        req1_central = 24'h0F0F0F; req1_radius = 12'h456; req1_mode = MODE_XOR;
        req1_lat = 2; req1_cand = 8'd66; req1_valid = 1'b1;
        k = 0;
        while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check_eq("t4_rsp_seen", rsp_valid, 1);
        tgt = acc_count + 1;
        for (int j = 0; j < 5; j++) begin
            check_eq("t4_req1_blocked", req1_ready, 0);
            check_eq("t4_no_en", eng_en, 0);
            check_eq("t4_hold_cand", rsp_candidate, 55);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_acc(tgt, "t4_req1_accept");
        req1_valid = 1'b0;
        wait_idle("t4_idle");

        // engine busy blocks acceptance
        req0_central = 24'h999999; req0_radius = 12'h888; req0_mode = MODE_TRIPLE;
        req0_lat = 4; req0_cand = 8'd77;
        eng_busy = 1'b1; req0_valid = 1'b1;
        tgt = acc_count + 1;
        for (int j = 0; j < 8; j++) begin
            check_eq("t5_blocked", req0_ready, 0);
            @(posedge clk); #1;
        end
        eng_busy = 1'b0;
        #1 check_eq("t5_accept_now", req0_ready, 1);
        wait_acc(tgt, "t5_accept");
        req0_valid = 1'b0;
        wait_idle("t5_idle");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_central = 24'($urandom); req1_central = 24'($urandom);
            req0_radius = 12'($urandom); req1_radius = 12'($urandom);
            req0_mode = 2'($urandom); req1_mode = 2'($urandom);
            req0_lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, TO));
            req1_lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, TO));
            req0_cand = 8'($urandom_range(0, 64)); req1_cand = 8'($urandom_range(0, 64));
            rsp_ready = ($urandom_range(0, 9) < 7);
            eng_busy = ($urandom_range(0, 9) < 2);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1; eng_busy = 1'b0;
        wait_idle("rand_idle");

        // asynchronous reset mid-WAIT, stale result afterwards
        send(0, 24'h246810, 12'h135, MODE_UNION, 12, 8'd9);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6_eng_en", eng_en, 0);
        check_eq("t6_rsp_valid", rsp_valid, 0);
        check_eq("t6_done_cnt", done_cnt, 0);
        check_eq("t6_rsp_cand", rsp_candidate, 0);
        req0_valid = 1'b1;
        #1 check_eq("t6_req0_ready", req0_ready, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        k = 0; stale = 0;
        while (!stale && k < 30) begin
            @(posedge clk); #2;
            if (eng_valid) stale = 1;
            k++;
        end
        check_eq("t6_stale_seen", stale, 1);
        repeat (3) @(posedge clk);
        #1 check_eq("t6_no_rsp", rsp_valid, 0);
        send(0, 24'h135791, 12'h246, MODE_A, 4, 8'd42);
        wait_idle("t6_idle");
        check_eq("t6_id", rsp_ids[rsp_ids.size()-1], 0);
        check_eq("t6_cand", rsp_cands[rsp_cands.size()-1], 42);
        check_eq("t6_done_final", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
